// File: rtl/watch_period_checker.sv
// watch_period_checker
// Measures the cycle period between successive rising edges of the tick
// counter's watch pulse, compares each period with the programmed tick count
// and queues {period, data snapshot, err} records in a small FIFO that is
// drained over a valid/ready port.
module watch_period_checker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic              watch_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] n_ticks_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  out_period_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_err_o,
  output logic              overflow_o,
  output logic [15:0]       pulse_cnt_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_watch_q;
  logic              w_event;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_cnt_sat;
  logic              w_push;
  logic              w_pc_inc;
  logic              w_err;
  logic [15:0]       r_pulse_cnt;
  logic              r_overflow;

  logic [CNT_W-1:0]  r_mem_period [DEPTH];
  logic [DATA_W-1:0] r_mem_data   [DEPTH];
  logic              r_mem_err    [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;

  // Rising-edge detect on the watch pulse; a held-high level is one event.
  assign w_event   = watch_i & ~r_watch_q;
  assign w_cnt_sat = (r_cnt == '1);
  // Saturation always flags the record, even if the tick count happens to match.
  assign w_err     = w_cnt_sat | (r_cnt != CNT_W'(n_ticks_i));

  // Edge-detect history register.
  always_ff @(posedge clk) begin
    if (!rstn) r_watch_q <= 1'b0;
    else       r_watch_q <= watch_i;
  end

  // FSM state and period counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, period counter update and push/count strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_pc_inc    = 1'b0;
    if (!en_i) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
        end
        S_ARMED: begin
          if (w_event) begin
            w_state_nxt = S_MEASURE;
            w_cnt_nxt   = CNT_W'(1);
            w_pc_inc    = 1'b1;
          end
        end
        S_MEASURE: begin
          if (w_event) begin
            w_push    = 1'b1;
            w_cnt_nxt = CNT_W'(1);
            w_pc_inc  = 1'b1;
          end else if (!w_cnt_sat) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Wrapping count of accepted events.
  always_ff @(posedge clk) begin
    if (!rstn)         r_pulse_cnt <= '0;
    else if (w_pc_inc) r_pulse_cnt <= r_pulse_cnt + 16'd1;
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = ~w_empty & out_ready_i;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  // FIFO storage; cleared on reset so head outputs read zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_period[i] <= '0;
        r_mem_data[i]   <= '0;
        r_mem_err[i]    <= 1'b0;
      end
    end else if (w_push_ok) begin
      r_mem_period[r_wr_ptr] <= r_cnt;
      r_mem_data[r_wr_ptr]   <= data_i;
      r_mem_err[r_wr_ptr]    <= w_err;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign out_valid_o  = ~w_empty;
  assign out_period_o = r_mem_period[r_rd_ptr];
  assign out_data_o   = r_mem_data[r_rd_ptr];
  assign out_err_o    = r_mem_err[r_rd_ptr];
  assign overflow_o   = r_overflow;
  assign pulse_cnt_o  = r_pulse_cnt;

endmodule

// File: tb/tb_watch_period_checker.sv
// Directed bench for watch_period_checker: a table of event gaps with
// expected records, plus hand-written overflow, simultaneous pop,
// saturation, held-level, enable and reset sequences.
module tb_watch_period_checker;

  logic        clk;
  logic        rstn;
  logic        en_i;
  logic        watch_i;
  logic [7:0]  data_i;
  logic [7:0]  n_ticks_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_period_o;
  logic [7:0]  out_data_o;
  logic        out_err_o;
  logic        overflow_o;
  logic [15:0] pulse_cnt_o;

  int unsigned n_checks;
  int unsigned n_err;
  logic [15:0] exp_pc;

  typedef struct {
    int unsigned gap;
    logic [7:0]  nt;
    logic [7:0]  d;
    logic [15:0] period;
    logic        err;
  } vec_t;

  vec_t vecs [7];

  watch_period_checker #(
    .DATA_W (8),
    .CNT_W  (16),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en_i         (en_i),
    .watch_i      (watch_i),
    .data_i       (data_i),
    .n_ticks_i    (n_ticks_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_period_o (out_period_o),
    .out_data_o   (out_data_o),
    .out_err_o    (out_err_o),
    .overflow_o   (overflow_o),
    .pulse_cnt_o  (pulse_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  // One-cycle watch pulse; the event lands on the next edge.
  task automatic send_event(input logic [7:0] d);
    watch_i = 1'b1;
    data_i  = d;
    step();
    watch_i = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn   = 1'b1;
    exp_pc = '0;
  endtask

  initial begin
    vecs[0] = '{gap: 10, nt: 8'd10, d: 8'h11, period: 16'd10, err: 1'b0};
    vecs[1] = '{gap: 10, nt: 8'd10, d: 8'h22, period: 16'd10, err: 1'b0};
    vecs[2] = '{gap:  9, nt: 8'd10, d: 8'h33, period: 16'd9,  err: 1'b1};
    vecs[3] = '{gap: 11, nt: 8'd10, d: 8'h44, period: 16'd11, err: 1'b1};
    vecs[4] = '{gap:  2, nt: 8'd10, d: 8'h55, period: 16'd2,  err: 1'b1};
    vecs[5] = '{gap:  2, nt: 8'd2,  d: 8'h66, period: 16'd2,  err: 1'b0};
    vecs[6] = '{gap:  5, nt: 8'd0,  d: 8'h77, period: 16'd5,  err: 1'b1};

    n_checks    = 0;
    n_err       = 0;
    exp_pc      = '0;
    rstn        = 1'b0;
    en_i        = 1'b0;
    watch_i     = 1'b0;
    data_i      = '0;
    n_ticks_i   = '0;
    out_ready_i = 1'b0;
    steps(2);

    chk("rst_valid",  32'(out_valid_o),  32'd0);
    chk("rst_period", 32'(out_period_o), 32'd0);
    chk("rst_data",   32'(out_data_o),   32'd0);
    chk("rst_err",    32'(out_err_o),    32'd0);
    chk("rst_ovf",    32'(overflow_o),   32'd0);
    chk("rst_pcnt",   32'(pulse_cnt_o),  32'd0);

    // Nominal and mismatch records from the table.
    rstn        = 1'b1;
    en_i        = 1'b1;
    out_ready_i = 1'b1;
    n_ticks_i   = 8'd10;
    step();
    send_event(8'h01);
    exp_pc = 16'd1;
    chk("arm_no_record", 32'(out_valid_o), 32'd0);
    chk("arm_pcnt",      32'(pulse_cnt_o), 32'(exp_pc));

    for (int i = 0; i < 7; i++) begin
      n_ticks_i = vecs[i].nt;
      steps(vecs[i].gap - 1);
      send_event(vecs[i].d);
      exp_pc++;
      chk($sformatf("vec%0d_valid", i),  32'(out_valid_o),  32'd1);
      chk($sformatf("vec%0d_period", i), 32'(out_period_o), 32'(vecs[i].period));
      chk($sformatf("vec%0d_err", i),    32'(out_err_o),    32'(vecs[i].err));
      chk($sformatf("vec%0d_data", i),   32'(out_data_o),   32'(vecs[i].d));
      chk($sformatf("vec%0d_pcnt", i),   32'(pulse_cnt_o),  32'(exp_pc));
    end

    // Enable dropped: event in the same cycle is ignored, re-arm needs a fresh first event.
    n_ticks_i = 8'd10;
    en_i      = 1'b0;
    send_event(8'h5A);
    chk("dis_pcnt",  32'(pulse_cnt_o), 32'(exp_pc));
    chk("dis_valid", 32'(out_valid_o), 32'd0);
    steps(2);
    en_i = 1'b1;
    step();
    send_event(8'h5B);
    exp_pc++;
    chk("rearm_no_record", 32'(out_valid_o), 32'd0);
    chk("rearm_pcnt",      32'(pulse_cnt_o), 32'(exp_pc));
    steps(9);
    send_event(8'h5C);
    exp_pc++;
    chk("rearm_valid",  32'(out_valid_o),  32'd1);
    chk("rearm_period", 32'(out_period_o), 32'd10);
    chk("rearm_err",    32'(out_err_o),    32'd0);

    // Overflow: four records held, fifth dropped, drain in order.
    out_ready_i = 1'b0;
    do_reset();
    step();
    send_event(8'hA0);
    exp_pc = 16'd1;
    for (int k = 1; k <= 5; k++) begin
      steps(9);
      send_event(8'(8'hA0 + k));
      exp_pc++;
      if (k == 4) chk("ovf_before", 32'(overflow_o), 32'd0);
      if (k == 5) chk("ovf_after",  32'(overflow_o), 32'd1);
    end
    chk("ovf_pcnt", 32'(pulse_cnt_o), 32'(exp_pc));
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i),  32'(out_valid_o),  32'd1);
      chk($sformatf("drain%0d_data", i),   32'(out_data_o),   32'(8'hA1 + i));
      chk($sformatf("drain%0d_period", i), 32'(out_period_o), 32'd10);
      step();
    end
    chk("drain_empty",  32'(out_valid_o), 32'd0);
    chk("drain_sticky", 32'(overflow_o),  32'd1);

    // Full FIFO with push and pop on the same edge.
    out_ready_i = 1'b0;
    do_reset();
    step();
    send_event(8'hB0);
    for (int k = 1; k <= 4; k++) begin
      steps(9);
      send_event(8'(8'hB0 + k));
    end
    steps(9);
    out_ready_i = 1'b1;
    send_event(8'hB5);
    chk("fullpop_ovf",   32'(overflow_o),  32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fullpop%0d_valid", i),  32'(out_valid_o),  32'd1);
      chk($sformatf("fullpop%0d_data", i),   32'(out_data_o),   32'(8'hB2 + i));
      chk($sformatf("fullpop%0d_period", i), 32'(out_period_o), 32'd10);
      step();
    end
    chk("fullpop_empty", 32'(out_valid_o), 32'd0);
    chk("fullpop_ovf2",  32'(overflow_o),  32'd0);

    // Saturation: second event far beyond the counter range.
    do_reset();
    step();
    send_event(8'hC0);
    exp_pc = 16'd1;
    steps(65539);
    send_event(8'hC1);
    exp_pc++;
    chk("sat_valid",  32'(out_valid_o),  32'd1);
    chk("sat_period", 32'(out_period_o), 32'hFFFF);
    chk("sat_err",    32'(out_err_o),    32'd1);
    chk("sat_data",   32'(out_data_o),   32'hC1);

    // Held-high watch counts once.
    steps(9);
    watch_i = 1'b1;
    data_i  = 8'hC2;
    step();
    exp_pc++;
    chk("held_valid",  32'(out_valid_o),  32'd1);
    chk("held_period", 32'(out_period_o), 32'd10);
    chk("held_err",    32'(out_err_o),    32'd0);
    chk("held_pcnt",   32'(pulse_cnt_o),  32'(exp_pc));
    steps(4);
    watch_i = 1'b0;
    step();
    chk("held_pcnt_once", 32'(pulse_cnt_o), 32'(exp_pc));
    chk("held_no_extra",  32'(out_valid_o), 32'd0);

    // Reset with two records queued.
    out_ready_i = 1'b0;
    steps(4);
    send_event(8'hD1);
    steps(9);
    send_event(8'hD2);
    exp_pc = exp_pc + 16'd2;
    chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
    chk("pre_rst_pcnt",  32'(pulse_cnt_o), 32'(exp_pc));
    rstn = 1'b0;
    step();
    chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
    chk("mid_rst_pcnt",  32'(pulse_cnt_o), 32'd0);
    chk("mid_rst_ovf",   32'(overflow_o),  32'd0);
    rstn = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/watch_period_checker.md
# watch_period_checker

Downstream monitor for the tick counter. It consumes the counter's `watch_o` pulse and `data_o` value, and measures the clock-cycle period between successive watch pulses. Each measured period is compared against the programmed tick count and queued as a record in a small FIFO, which software-side or test logic drains over a valid/ready port.

## Interface

Reset is synchronous and active-low (`rstn`) on the single clock `clk`.

Parameters:
- `DATA_W`, default 8: width of the counter value and of the tick count.
- `CNT_W`, default 16: width of the period counter; must be greater than `DATA_W`.
- `DEPTH`, default 4: number of FIFO records; must be a power of two, at least 2.

Ports:
- `clk`  input  1  clock; all logic is rising-edge.
- `rstn`  input  1  synchronous active-low reset.
- `en_i`  input  1  measurement enable.
- `watch_i`  input  1  watch pulse from the counter.
- `data_i`  input  DATA_W  counter value; snapshotted at each event.
- `n_ticks_i`  input  DATA_W  expected period in cycles, the same value programmed into the counter.
- `out_valid_o`  output  1  FIFO head record is valid.
- `out_ready_i`  input  1  consumer accepts the head record.
- `out_period_o`  output  CNT_W  measured period of the head record.
- `out_data_o`  output  DATA_W  `data_i` snapshot of the head record.
- `out_err_o`  output  1  head record period mismatch or saturation.
- `overflow_o`  output  1  sticky flag: a record was dropped because the FIFO was full.
- `pulse_cnt_o`  output  16  count of detected events, wrapping.

## Operation

Event detection:
- `watch_q` registers `watch_i`.
- An event occurs at a clock edge where `watch_i`=1 and `watch_q`=0.
- A level held high counts as one event only.

FSM states:
- **IDLE:** period counter is 0 and events are ignored. Moves to ARMED when `en_i`=1.
- **ARMED:** the first event loads the period counter with 1, moves to MEASURE, and pushes no record.
- **MEASURE:**
  - The period counter increments each cycle and saturates at all-ones.
  - On an event, push the record {period = counter value, data = `data_i`, err}, then reload the counter with 1.
- From any state, `en_i`=0 forces IDLE at the next edge and clears the period counter. An event in that same cycle is ignored.

Record arithmetic:
- Period = the number of edges between the two events. Events at edges t0 and t1 give period = t1 − t0.
- err = 1 if the counter is saturated, or if the period ≠ zero-extended `n_ticks_i` (sampled at the push edge).
- `n_ticks_i`=0 therefore flags every record.

`pulse_cnt_o` increments on every event in ARMED or MEASURE and wraps from 0xFFFF to 0.

FIFO behaviour:
- Pop occurs when `out_valid_o` and `out_ready_i` are both 1.
- Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- If a push arrives while full with no pop, the record is dropped and `overflow_o` sets.
- `overflow_o` clears only on reset.
- Pointers wrap modulo `DEPTH`.
- Push and pop in the same cycle on an empty FIFO: no pop is possible, so the push lands and `out_valid_o` rises next cycle.
- The FIFO keeps draining while `en_i`=0.
- `out_period_o`, `out_data_o` and `out_err_o` are don't-care while `out_valid_o`=0.

## Timing

- Reset values, at the first edge with `rstn`=0:
  - State is IDLE.
  - `out_valid_o`, `out_period_o`, `out_data_o`, `out_err_o`, `overflow_o` and `pulse_cnt_o` are all 0.
  - FIFO is empty, `watch_q`=0, period counter is 0.
- Reset mid-operation discards all FIFO contents and in-flight measurement.
- Latency: an event detected at edge k makes the record visible with `out_valid_o`=1 after edge k, provided the FIFO was empty.
- `pulse_cnt_o` updates at edge k.
- Throughput: one pop per cycle; back-to-back events two cycles apart are recorded.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Nominal:** `n_ticks_i`=10, enable, watch pulses every 10 cycles, `out_ready_i`=1. First event produces no record; each later record has period=10 and err=0; `pulse_cnt_o` increments per pulse.
- **Mismatch:** `n_ticks_i`=10, pulses spaced 9 then 11 cycles. Records have period=9, err=1, then period=11, err=1. With `n_ticks_i`=0, every record has err=1.
- **Overflow:** `DEPTH`=4, `out_ready_i`=0, 6 periodic pulses. 4 records are held, the 5th is dropped, and `overflow_o`=1 one cycle after that push. Draining returns the 4 records in order, and `overflow_o` stays 1.
- **Full with simultaneous pop:** FIFO full, event and pop on the same edge. Push is accepted, occupancy stays 4, and `overflow_o` stays 0.
- **Saturation and held level:** `CNT_W`=16, second pulse more than 65535 cycles later. Record has period=0xFFFF and err=1. A `watch_i` held high for 5 cycles counts as one event.
- **Enable and reset mid-run:** drop `en_i` between pulses. The next pulse after re-enable produces no record. Asserting `rstn`=0 with 2 records queued clears `out_valid_o`, `pulse_cnt_o` and `overflow_o` to 0 at that edge.
